// File: rtl/sync_fifo_if.sv
// Write/read handshake, status and threshold bundle for sync_fifo_param.
interface sync_fifo_if #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned DEPTH_WIDTH = 11
);
  logic                   wr_en;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic                   rd_en;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   rd_valid;
  logic                   wr_full;
  logic                   rd_empty;
  logic [DEPTH_WIDTH:0]   af_thresh;
  logic [DEPTH_WIDTH:0]   ae_thresh;
  logic                   almost_full;
  logic                   almost_empty;
  logic [DEPTH_WIDTH:0]   water_level;
  logic                   overflow;
  logic                   underflow;
  logic                   err_clr;

  modport master (
    output wr_en, wr_data, rd_en, af_thresh, ae_thresh, err_clr,
    input  rd_data, rd_valid, wr_full, rd_empty, almost_full, almost_empty,
           water_level, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, af_thresh, ae_thresh, err_clr,
    output rd_data, rd_valid, wr_full, rd_empty, almost_full, almost_empty,
           water_level, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with block-RAM storage, optional FWFT output
// stage, programmable almost-full/empty thresholds and sticky error flags.
module sync_fifo_param #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned DEPTH_WIDTH = 11,
  parameter bit          FWFT        = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  sync_fifo_if.slave bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_WIDTH;
  localparam int unsigned PTR_W = DEPTH_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      level;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  overflow_q;
  logic                  underflow_q;

  logic wr_full_c;
  logic rd_empty_c;
  logic wr_acc_c;
  logic rd_acc_c;
  logic ram_rd_c;
  logic rd_valid_c;

  // Accept decisions use only state registered at the start of the cycle
  assign wr_full_c = (level == PTR_W'(DEPTH));
  assign wr_acc_c  = bus.wr_en & ~wr_full_c;
  assign rd_acc_c  = bus.rd_en & ~rd_empty_c;

  always_ff @(posedge clk) begin
    if (wr_acc_c) begin
      mem[wr_ptr[DEPTH_WIDTH-1:0]] <= bus.wr_data;
    end
  end

  // Registered RAM read doubles as the output data register in both modes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (ram_rd_c) begin
      rd_data_q <= mem[rd_ptr[DEPTH_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (ram_rd_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_acc_c, rd_acc_c})
        2'b10:   level <= level + PTR_W'(1);
        2'b01:   level <= level - PTR_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Sticky errors; a new drop in the clearing cycle keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wr_en & wr_full_c) begin
        overflow_q <= 1'b1;
      end else if (bus.err_clr) begin
        overflow_q <= 1'b0;
      end
      if (bus.rd_en & rd_empty_c) begin
        underflow_q <= 1'b1;
      end else if (bus.err_clr) begin
        underflow_q <= 1'b0;
      end
    end
  end

  if (FWFT) begin : g_fwft
    logic             head_valid;
    logic [PTR_W-1:0] ram_count_c;

    // Refill the head register when it is empty or being popped
    assign ram_count_c = wr_ptr - rd_ptr;
    assign ram_rd_c    = (~head_valid | rd_acc_c) & (ram_count_c != '0);
    assign rd_empty_c  = ~head_valid;
    assign rd_valid_c  = head_valid;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        head_valid <= 1'b0;
      end else if (ram_rd_c) begin
        head_valid <= 1'b1;
      end else if (rd_acc_c) begin
        head_valid <= 1'b0;
      end
    end
  end else begin : g_std
    logic rd_valid_q;

    assign ram_rd_c   = rd_acc_c;
    assign rd_empty_c = (level == '0);
    assign rd_valid_c = rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc_c;
      end
    end
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_c;
  assign bus.wr_full      = wr_full_c;
  assign bus.rd_empty     = rd_empty_c;
  assign bus.almost_full  = (level >= bus.af_thresh);
  assign bus.almost_empty = (level <= bus.ae_thresh);
  assign bus.water_level  = level;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: standard and FWFT instances share stimulus and are
// checked each cycle against queue models plus directed literal expectations.
module tb_sync_fifo_param;
  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 4;
  localparam int          DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, rd_en, err_clr;
  logic [DW-1:0] wr_data;
  logic [AW:0]   af_thresh, ae_thresh;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: words held per mode, plus visible-head flag for FWFT
  logic [DW-1:0] qs[$];
  logic [DW-1:0] qf[$];
  logic [DW-1:0] m_std_data;
  logic          m_std_valid, m_shown;
  logic          m_ovf_s, m_unf_s, m_ovf_f, m_unf_f;

  always #5 clk = ~clk;

  sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW)) if_s ();
  sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW)) if_f ();

  assign if_s.wr_en = wr_en;   assign if_f.wr_en = wr_en;
  assign if_s.wr_data = wr_data; assign if_f.wr_data = wr_data;
  assign if_s.rd_en = rd_en;   assign if_f.rd_en = rd_en;
  assign if_s.err_clr = err_clr; assign if_f.err_clr = err_clr;
  assign if_s.af_thresh = af_thresh; assign if_f.af_thresh = af_thresh;
  assign if_s.ae_thresh = ae_thresh; assign if_f.ae_thresh = ae_thresh;

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .FWFT(1'b0)) u_std (
    .clk(clk), .rst_n(rst_n), .bus(if_s.slave));
  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .bus(if_f.slave));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    qs.delete();
    qf.delete();
    m_std_data  = '0;
    m_std_valid = 1'b0;
    m_shown     = 1'b0;
    m_ovf_s = 1'b0; m_unf_s = 1'b0; m_ovf_f = 1'b0; m_unf_f = 1'b0;
  endtask

  // One clock edge of both reference FIFOs, from the inputs applied at it
  task automatic model_edge();
    bit wa_s, wa_f, pop;
    int ram_words;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (wr_en && qs.size() == DEPTH) m_ovf_s = 1'b1; else if (err_clr) m_ovf_s = 1'b0;
    if (rd_en && qs.size() == 0)     m_unf_s = 1'b1; else if (err_clr) m_unf_s = 1'b0;
    wa_s        = wr_en && qs.size() < DEPTH;
    m_std_valid = rd_en && qs.size() != 0;
    if (m_std_valid) m_std_data = qs.pop_front();
    if (wa_s) qs.push_back(wr_data);

    if (wr_en && qf.size() == DEPTH) m_ovf_f = 1'b1; else if (err_clr) m_ovf_f = 1'b0;
    if (rd_en && !m_shown)           m_unf_f = 1'b1; else if (err_clr) m_unf_f = 1'b0;
    wa_f      = wr_en && qf.size() < DEPTH;
    pop       = rd_en && m_shown;
    ram_words = qf.size() - (m_shown ? 1 : 0);
    m_shown   = (m_shown && !pop) || (ram_words > 0);
    if (pop) void'(qf.pop_front());
    if (wa_f) qf.push_back(wr_data);
  endtask

  task automatic step(input bit we, input logic [DW-1:0] wd, input bit re, input bit ec);
    wr_en = we; wr_data = wd; rd_en = re; err_clr = ec;
    @(posedge clk);
    model_edge();
    #2;
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " s.level"}, 32'(if_s.water_level), 0);
    chk({tag, " f.level"}, 32'(if_f.water_level), 0);
    chk({tag, " s.empty"}, 32'(if_s.rd_empty), 1);
    chk({tag, " f.empty"}, 32'(if_f.rd_empty), 1);
    chk({tag, " s.full"}, 32'(if_s.wr_full), 0);
    chk({tag, " s.ae"}, 32'(if_s.almost_empty), 1);
    chk({tag, " s.af"}, 32'(if_s.almost_full), 0);
    chk({tag, " s.valid"}, 32'(if_s.rd_valid), 0);
    chk({tag, " f.valid"}, 32'(if_f.rd_valid), 0);
    chk({tag, " s.data"}, 32'(if_s.rd_data), 0);
    chk({tag, " f.data"}, 32'(if_f.rd_data), 0);
    chk({tag, " s.ovf"}, 32'(if_s.overflow), 0);
    chk({tag, " f.unf"}, 32'(if_f.underflow), 0);
  endtask

  // Per-cycle comparison against the models
  initial begin
    forever begin
      @(negedge clk);
      chk("s.level", 32'(if_s.water_level), 32'(qs.size()));
      chk("s.full", 32'(if_s.wr_full), 32'(qs.size() == DEPTH));
      chk("s.empty", 32'(if_s.rd_empty), 32'(qs.size() == 0));
      chk("s.valid", 32'(if_s.rd_valid), 32'(m_std_valid));
      chk("s.data", 32'(if_s.rd_data), 32'(m_std_data));
      chk("s.af", 32'(if_s.almost_full), 32'(qs.size() >= int'(af_thresh)));
      chk("s.ae", 32'(if_s.almost_empty), 32'(qs.size() <= int'(ae_thresh)));
      chk("s.ovf", 32'(if_s.overflow), 32'(m_ovf_s));
      chk("s.unf", 32'(if_s.underflow), 32'(m_unf_s));
      chk("f.level", 32'(if_f.water_level), 32'(qf.size()));
      chk("f.full", 32'(if_f.wr_full), 32'(qf.size() == DEPTH));
      chk("f.empty", 32'(if_f.rd_empty), 32'(!m_shown));
      chk("f.valid", 32'(if_f.rd_valid), 32'(m_shown));
      if (m_shown) chk("f.data", 32'(if_f.rd_data), 32'(qf[0]));
      chk("f.af", 32'(if_f.almost_full), 32'(qf.size() >= int'(af_thresh)));
      chk("f.ae", 32'(if_f.almost_empty), 32'(qf.size() <= int'(ae_thresh)));
      chk("f.ovf", 32'(if_f.overflow), 32'(m_ovf_f));
      chk("f.unf", 32'(if_f.underflow), 32'(m_unf_f));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = '0;
    af_thresh = 5'd12; ae_thresh = 5'd3;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    chk_reset_vals("por");
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Fill 0..15 with threshold and FWFT latency checks along the way
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0);
      chk("fill s.level", 32'(if_s.water_level), 32'(i + 1));
      chk("fill s.af", 32'(if_s.almost_full), 32'(i + 1 >= 12));
      chk("fill s.ae", 32'(if_s.almost_empty), 32'(i + 1 <= 3));
      if (i == 0) begin
        chk("fill0 s.empty", 32'(if_s.rd_empty), 0);
        chk("fill0 f.empty", 32'(if_f.rd_empty), 1);
      end
      if (i == 1) begin
        chk("fill1 f.empty", 32'(if_f.rd_empty), 0);
        chk("fill1 f.data", 32'(if_f.rd_data), 0);
      end
    end
    chk("full s.full", 32'(if_s.wr_full), 1);
    chk("full f.full", 32'(if_f.wr_full), 1);
    chk("full f.level", 32'(if_f.water_level), 16);

    step(1'b1, 16'hBEEF, 1'b0, 1'b0);
    chk("ovf17 s.ovf", 32'(if_s.overflow), 1);
    chk("ovf17 f.ovf", 32'(if_f.overflow), 1);
    chk("ovf17 s.level", 32'(if_s.water_level), 16);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("clr s.ovf", 32'(if_s.overflow), 0);

    // Simultaneous read and write while full
    step(1'b1, 16'hCAFE, 1'b1, 1'b0);
    chk("fullrw s.ovf", 32'(if_s.overflow), 1);
    chk("fullrw s.level", 32'(if_s.water_level), 15);
    chk("fullrw s.data", 32'(if_s.rd_data), 0);
    chk("fullrw s.valid", 32'(if_s.rd_valid), 1);
    chk("fullrw f.data", 32'(if_f.rd_data), 1);
    chk("fullrw f.level", 32'(if_f.water_level), 15);

    // err_clr coinciding with a new overflow leaves it set
    step(1'b1, 16'h0010, 1'b0, 1'b0);
    step(1'b1, 16'hDEAD, 1'b0, 1'b1);
    chk("clrset s.ovf", 32'(if_s.overflow), 1);
    chk("clrset f.ovf", 32'(if_f.overflow), 1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("clr2 f.ovf", 32'(if_f.overflow), 0);

    for (int j = 1; j <= DEPTH; j++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      chk("drain s.data", 32'(if_s.rd_data), 32'(j));
      chk("drain s.valid", 32'(if_s.rd_valid), 1);
      chk("drain s.af", 32'(if_s.almost_full), 32'(16 - j >= 12));
      chk("drain s.ae", 32'(if_s.almost_empty), 32'(16 - j <= 3));
    end
    chk("drained s.empty", 32'(if_s.rd_empty), 1);
    chk("drained f.empty", 32'(if_f.rd_empty), 1);
    chk("drained f.level", 32'(if_f.water_level), 0);

    // Simultaneous read and write while empty
    step(1'b1, 16'h0055, 1'b1, 1'b0);
    chk("emptyrw s.level", 32'(if_s.water_level), 1);
    chk("emptyrw s.unf", 32'(if_s.underflow), 1);
    chk("emptyrw f.unf", 32'(if_f.underflow), 1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("clr s.unf", 32'(if_s.underflow), 0);
    chk("late f.data", 32'(if_f.rd_data), 32'h55);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("rd55 s.data", 32'(if_s.rd_data), 32'h55);

    // FWFT one-RAM-cycle latency
    step(1'b1, 16'hA5A5, 1'b0, 1'b0);
    chk("lat k f.empty", 32'(if_f.rd_empty), 1);
    chk("lat k s.empty", 32'(if_s.rd_empty), 0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("lat k1 f.empty", 32'(if_f.rd_empty), 0);
    chk("lat k1 f.data", 32'(if_f.rd_data), 32'hA5A5);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("pop f.empty", 32'(if_f.rd_empty), 1);
    chk("pop f.level", 32'(if_f.water_level), 0);
    chk("pop s.data", 32'(if_s.rd_data), 32'hA5A5);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("idle s.valid", 32'(if_s.rd_valid), 0);

    // Run-time threshold change is seen combinationally
    for (int i = 0; i < 10; i++) step(1'b1, DW'(16'h100 + i), 1'b0, 1'b0);
    chk("lvl10 s.af", 32'(if_s.almost_full), 0);
    af_thresh = 5'd8;
    #1;
    chk("af8 s.af", 32'(if_s.almost_full), 1);
    chk("af8 f.af", 32'(if_f.almost_full), 1);
    af_thresh = 5'd12;
    #1;
    chk("af12 s.af", 32'(if_s.almost_full), 0);

    // Reset mid-stream at level 7
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("lvl7 s.level", 32'(if_s.water_level), 7);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset_vals("mid");
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #2;
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    step(1'b1, 16'h5678, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("post f.data", 32'(if_f.rd_data), 32'h1234);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("post s.data", 32'(if_s.rd_data), 32'h1234);
    chk("post2 f.data", 32'(if_f.rd_data), 32'h5678);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("post2 s.data", 32'(if_s.rd_data), 32'h5678);

    // Random traffic: fill-biased then drain-biased
    for (int i = 0; i < 200; i++) begin
      step($urandom_range(0, 99) < (i < 100 ? 75 : 30), DW'($urandom),
           $urandom_range(0, 99) < (i < 100 ? 35 : 75), $urandom_range(0, 19) == 0);
    end
    step(1'b0, '0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
